// File: rtl/cdb_arbiter.sv
`timescale 1ns/1ps
// Common data bus arbiter: round-robin among requesters with a starvation override,
// combinational one-hot grant and a registered winning payload one cycle later.
module cdb_arbiter #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 37,
  parameter int STARVE = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   payload,
  input  logic                    flush,
  input  logic                    stall,
  output logic [NREQ-1:0]         grant,
  output logic [WIDTH-1:0]        cdb_out,
  output logic                    cdb_en
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (STARVE > 0) ? $clog2(STARVE + 1) : 1;

  logic [PW-1:0]    rr_ptr;
  logic [CW-1:0]    wcnt [NREQ];
  logic [NREQ-1:0]  starve_vec;
  logic [PW-1:0]    rr_idx;
  logic [PW-1:0]    st_idx;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    cand;
  logic [PW-1:0]    rr_next;
  logic             rr_found;
  logic [WIDTH-1:0] win_payload;

  always_comb begin
    starve_vec  = '0;
    rr_idx      = '0;
    st_idx      = '0;
    cand        = '0;
    rr_found    = 1'b0;
    grant       = '0;
    for (int i = 0; i < NREQ; i++)
      starve_vec[i] = req[i] && (wcnt[i] == CW'(STARVE));
    // Walk the request vector starting at rr_ptr, wrapping modulo NREQ.
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(rr_ptr) + k) % NREQ);
      if (!rr_found && req[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
    // Descending scan leaves the lowest starving index.
    for (int i = NREQ - 1; i >= 0; i--)
      if (starve_vec[i]) st_idx = PW'(i);
    win_idx     = (|starve_vec) ? st_idx : rr_idx;
    win_payload = payload[int'(win_idx)*WIDTH +: WIDTH];
    rr_next     = PW'((int'(win_idx) + 1) % NREQ);
    if (rst && !flush && !stall && (|req))
      grant[win_idx] = 1'b1;
  end

  // Stage boundary: registered bus output, pointer and wait counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr  <= '0;
      cdb_en  <= 1'b0;
      cdb_out <= '0;
      for (int i = 0; i < NREQ; i++) wcnt[i] <= '0;
    end else begin
      cdb_en <= |grant;
      if (|grant) begin
        cdb_out <= win_payload;
        rr_ptr  <= rr_next;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (flush)
          wcnt[i] <= '0;
        else if (stall)
          wcnt[i] <= wcnt[i];
        else if (grant[i] || !req[i])
          wcnt[i] <= '0;
        else if (wcnt[i] != CW'(STARVE))
          wcnt[i] <= wcnt[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
`timescale 1ns/1ps
// Bench for cdb_arbiter: two instances (default STARVE and STARVE=2) checked every
// cycle against a behavioural model, plus directed literal expectations.
module tb_cdb_arbiter;
  localparam int N = 4;
  localparam int W = 37;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [N-1:0]         req = '0;
  logic [N*W-1:0]       payload;
  logic                 flush = 1'b0;
  logic                 stall = 1'b0;
  logic [1:0][N-1:0]    gnt;
  logic [1:0][W-1:0]    cout;
  logic [1:0]           cen;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NREQ(N), .WIDTH(W), .STARVE(7)) u_a (
    .clk(clk), .rst(rst), .req(req), .payload(payload), .flush(flush), .stall(stall),
    .grant(gnt[0]), .cdb_out(cout[0]), .cdb_en(cen[0]));

  cdb_arbiter #(.NREQ(N), .WIDTH(W), .STARVE(2)) u_b (
    .clk(clk), .rst(rst), .req(req), .payload(payload), .flush(flush), .stall(stall),
    .grant(gnt[1]), .cdb_out(cout[1]), .cdb_en(cen[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: one entry per instance.
  int             m_starve [2] = '{7, 2};
  int             m_rr  [2];
  int             m_w   [2][N];
  logic           m_en  [2];
  logic [W-1:0]   m_out [2];
  int             n_rr  [2];
  int             n_w   [2][N];
  logic           n_en  [2];
  logic [W-1:0]   n_out [2];
  logic           commit;

  function automatic int pick(input int u);
    if (flush || stall || req == '0) return -1;
    for (int i = 0; i < N; i++)
      if (req[i] && m_w[u][i] == m_starve[u]) return i;
    for (int k = 0; k < N; k++)
      if (req[(m_rr[u] + k) % N]) return (m_rr[u] + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_rr[u] = 0; m_en[u] = 1'b0; m_out[u] = '0;
      for (int i = 0; i < N; i++) m_w[u][i] = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      commit = rst;
      if (!rst) begin
        model_reset();
        for (int u = 0; u < 2; u++) begin
          chk($sformatf("rst_grant%0d", u), 64'(gnt[u]), 64'd0);
          chk($sformatf("rst_en%0d", u), 64'(cen[u]), 64'd0);
        end
      end else begin
        for (int u = 0; u < 2; u++) begin
          int g;
          logic [N-1:0] eg;
          g  = pick(u);
          eg = (g < 0) ? '0 : N'(1 << g);
          chk($sformatf("grant%0d", u), 64'(gnt[u]), 64'(eg));
          chk($sformatf("cdb_en%0d", u), 64'(cen[u]), 64'(m_en[u]));
          chk($sformatf("cdb_out%0d", u), 64'(cout[u]), 64'(m_out[u]));
          for (int i = 0; i < N; i++) begin
            if (flush)                    n_w[u][i] = 0;
            else if (stall)               n_w[u][i] = m_w[u][i];
            else if (i == g || !req[i])   n_w[u][i] = 0;
            else if (m_w[u][i] < m_starve[u]) n_w[u][i] = m_w[u][i] + 1;
            else                          n_w[u][i] = m_w[u][i];
          end
          n_rr[u]  = (g >= 0) ? (g + 1) % N : m_rr[u];
          n_en[u]  = (g >= 0);
          n_out[u] = (g >= 0) ? payload[g*W +: W] : m_out[u];
        end
      end
      @(posedge clk);
      if (commit && rst) begin
        for (int u = 0; u < 2; u++) begin
          m_rr[u] = n_rr[u]; m_en[u] = n_en[u]; m_out[u] = n_out[u];
          for (int i = 0; i < N; i++) m_w[u][i] = n_w[u][i];
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    n_err++;
    $display("FAIL timeout: got running expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    payload = {37'h04_A0000003, 37'h03_A0000002, 37'h02_A0000001, 37'h05_DEADBEEF};
    req = 4'b1111;
    #3;
    chk("reset_grant", 64'(gnt[0]), 64'd0);
    chk("reset_en", 64'(cen[0]), 64'd0);
    chk("reset_out", 64'(cout[0]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    req = '0;

    // Single request, one-cycle latency, pointer moves to 1.
    step(); req = 4'b0001; #2;
    chk("t028_grant", 64'(gnt[0]), 64'(4'b0001));
    step(); req = '0; #2;
    chk("t028_en", 64'(cen[0]), 64'd1);
    chk("t028_out", 64'(cout[0]), 64'h05_DEADBEEF);
    step(); req = 4'b0011; #2;
    chk("t028_rr1", 64'(gnt[0]), 64'(4'b0010));
    step(); req = '0;

    // Stall holds everything off.
    do_reset();
    req = 4'b0011; stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("t030_grant", 64'(gnt[0]), 64'd0);
      chk("t030_en", 64'(cen[0]), 64'd0);
      step();
    end
    stall = 1'b0; #2;
    chk("t030_release", 64'(gnt[0]), 64'(4'b0001));
    step(); req = '0;

    // Full contention rotates strictly.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #2;
      chk("t029_grant", 64'(gnt[0]), 64'(1 << (k % 4)));
      chk("t029_en", 64'(cen[0]), 64'(k > 0));
      step();
    end
    req = '0; #2;
    chk("t029_en_last", 64'(cen[0]), 64'd1);
    step();

    // Starvation override on the STARVE=2 instance.
    do_reset();
    req = 4'b0001;
    step(); req = 4'b0111; #2;
    chk("t031_g1", 64'(gnt[1]), 64'(4'b0010));
    step(); req = 4'b0101; #2;
    chk("t031_g2", 64'(gnt[1]), 64'(4'b0100));
    step(); req = 4'b1111; #2;
    chk("t031_override", 64'(gnt[1]), 64'(4'b0001));
    chk("t031_rr_only", 64'(gnt[0]), 64'(4'b1000));
    step(); req = '0;

    // Flush the cycle after a grant to requester 2.
    do_reset();
    req = 4'b0100; #2;
    chk("t032_grant", 64'(gnt[0]), 64'(4'b0100));
    step(); flush = 1'b1; #2;
    chk("t032_flush_grant", 64'(gnt[0]), 64'd0);
    chk("t032_flush_en", 64'(cen[0]), 64'd1);
    step(); flush = 1'b0; req = '0; #2;
    chk("t032_after_en", 64'(cen[0]), 64'd0);
    step(); req = 4'b1001; #2;
    chk("t032_rr3_a", 64'(gnt[0]), 64'(4'b1000));
    chk("t032_rr3_b", 64'(gnt[1]), 64'(4'b1000));
    step(); req = '0;

    // Asynchronous reset between edges while the bus is valid.
    step(); req = 4'b0001;
    step(); #1;
    chk("t033_en_before", 64'(cen[0]), 64'd1);
    #1; rst = 1'b0; #1;
    chk("t033_en", 64'(cen[0]), 64'd0);
    chk("t033_out", 64'(cout[0]), 64'd0);
    chk("t033_grant", 64'(gnt[0]), 64'd0);
    chk("t033_grant_b", 64'(gnt[1]), 64'd0);
    step(); rst = 1'b1; req = '0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
